// File: rtl/decade_counter_pkg.sv
// Shared constants and next-state helper for the BCD decade counter.
package decade_counter_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd9;
  localparam logic [CNT_W-1:0] CNT_RST = 4'd0;

  // Values at or above the terminal count (including illegal 10..15) all return to zero.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur);
    if (cur >= CNT_MAX) begin
      return CNT_RST;
    end
    return cur + CNT_W'(1);
  endfunction

endpackage

// File: rtl/t_flip_flop.sv
// 1-bit toggle flip-flop with synchronous active-high reset.
module t_flip_flop (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/decade_counter_4bit.sv
// BCD counter 0..9 built from four T flip-flops; each state bit is a separate output.
module decade_counter_4bit
  import decade_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] t_w;

  // A T flip-flop reaches the target value when toggled exactly where current and next differ.
  always_comb begin
    cnt_d = next_count(cnt_q);
  end

  assign t_w = cnt_q ^ cnt_d;

  for (genvar i = 0; i < CNT_W; i++) begin : g_ff
    t_flip_flop u_ff (
      .clk (clk),
      .rst (rst),
      .t   (t_w[i]),
      .q   (cnt_q[i])
    );
  end

  assign out1 = cnt_q[0];
  assign out2 = cnt_q[1];
  assign out3 = cnt_q[2];
  assign out4 = cnt_q[3];

endmodule

// File: tb/tb_decade_counter_4bit.sv
// Directed self-checking bench for decade_counter_4bit.
module tb_decade_counter_4bit;

  logic clk;
  logic rst;
  logic out1, out2, out3, out4;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  decade_counter_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3),
    .out4 (out4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {out4, out3, out2, out1};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: drive rst after the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic r, input string name, input logic [3:0] exp);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // Drive the T inputs directly for one edge to load an arbitrary (possibly illegal) value from 0.
  task automatic load_from_zero(input logic [3:0] val);
    @(negedge clk);
    rst = 1'b0;
    force dut.t_w = val;
    @(posedge clk);
    #1;
    release dut.t_w;
    check("illegal_load", val);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;

    // Reset across the 10 ns edge, released at 15 ns.
    #5 rst = 1'b1;
    @(posedge clk);
    #5 rst = 1'b0;
    #5 check("reset_start", 4'd0);

    // Free run through the 990 ns edge: k-th edge after reset shows k mod 10.
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
      check("count_wrap", 4'(k % 10));
    end

    // Table: resync, count to 6, mid-count reset, resume, reset held 5 edges, resume.
    vecs.push_back('{1'b1, 4'd0});
    for (int v = 1; v <= 6; v++) vecs.push_back('{1'b0, 4'(v)});
    vecs.push_back('{1'b1, 4'd0});
    vecs.push_back('{1'b0, 4'd1});
    for (int v = 0; v < 5; v++) vecs.push_back('{1'b1, 4'd0});
    vecs.push_back('{1'b0, 4'd1});
    vecs.push_back('{1'b0, 4'd2});
    foreach (vecs[i]) step(vecs[i].rst, $sformatf("table[%0d]", i), vecs[i].exp);

    // Illegal state 12 recovers to 0 in one edge, then counts.
    step(1'b1, "pre_illegal12", 4'd0);
    load_from_zero(4'b1100);
    step(1'b0, "recover12", 4'd0);
    step(1'b0, "after12", 4'd1);

    // Illegal state 15 likewise.
    step(1'b1, "pre_illegal15", 4'd0);
    load_from_zero(4'b1111);
    step(1'b0, "recover15", 4'd0);
    step(1'b0, "after15", 4'd1);

    // Illegal state 10, the first value past the terminal count.
    step(1'b1, "pre_illegal10", 4'd0);
    load_from_zero(4'b1010);
    step(1'b0, "recover10", 4'd0);

    // Short reset pulse between edges is ignored.
    step(1'b0, "pre_pulse", 4'd1);
    step(1'b0, "pre_pulse", 4'd2);
    @(negedge clk);
    rst = 1'b1;
    #5 rst = 1'b0;
    @(posedge clk);
    #1 check("short_pulse", 4'd3);
    step(1'b0, "post_pulse", 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
